gen3_frame_tx: RTL and testbench
================================

// Module: gen3_frame_tx
// PURPOSE
//  Gen3 128b/130b transmit framer: wraps upstream TLP/DLLP byte streams in STP/SDP framing tokens and terminators.
//  Sits between the TX link layer and the lane byte path; its output is the exact byte framing parsed by the RX byte checker.
//  Generates the 12-bit TLP sequence number and tags every output byte with the receiver's 6-bit type code.
// PARAMETERS
//  END_BYTE    8'h1F  terminator byte for a good TLP
//  EDB_BYTE    8'hC0  terminator byte for a nullified/errored TLP (RX reports tlpedb)
//  DLLP_PAD    8'h00  trailing byte after the 6 DLLP bytes (RX reports dllpend)
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous reset, active high
//  in_valid        in   1   upstream byte valid
//  in_ready        out  1   upstream byte accepted when in_valid&&in_ready
//  in_data         in   8   packet byte
//  in_sop          in   1   first byte of packet; in_is_dllp/in_len_dw qualified here
//  in_eop          in   1   last byte of packet; in_nullify qualified here
//  in_is_dllp      in   1   1=DLLP (6 bytes), 0=TLP
//  in_len_dw       in   10  TLP length in DW, 1..1023
//  in_nullify      in   1   end TLP with EDB_BYTE
//  out_valid       out  1   output byte valid
//  out_ready       in   1   lane accepts byte when out_valid&&out_ready
//  out_data        out  8   framed byte
//  out_sync_header out  2   2'b01 while out_valid, else 2'b00
//  out_type        out  6   100000 data,010000 tlpstart,001000 tlpend,000010 dllpstart,000100 dllpend,000001 tlpedb,0 other
//  tx_seq          out  12  sequence number for next TLP
//  frame_err       out  1   1-cycle pulse on framing error
// BEHAVIOUR
//  - Reset: all outputs 0, tx_seq=0, FSM IDLE; reset mid-packet aborts without emitting a terminator.
//  - Output register loads only when !out_valid||out_ready; out_data/out_type held stable while stalled.
//  - FSM IDLE,STP0..STP3,SDP0,SDP1,PAYLOAD,TERM,DROP; one output byte per advance.
//  - IDLE: in_valid&&in_sop peeked (not consumed); latch type/len/nullify; next state STP0 or SDP0.
//    in_valid&&!in_sop in IDLE: byte consumed and discarded, frame_err pulse.
//    in_sop with TLP len 0: enter DROP, frame_err pulse, no token emitted.
//  - STP0={len[3:0],4'hF}, STP1=len[11:4] (len zero-extended), STP2={4'h0,tx_seq[11:8]},
//    STP3=tx_seq[7:0] typed tlpstart; other token bytes type 0.
//  - SDP0=8'hF0 type 0, SDP1=8'hAC typed dllpstart.
//  - PAYLOAD: in_ready = !out_valid||out_ready; byte passed through typed data;
//    limit = len_dw<<2 bytes (TLP) or 6 (DLLP); 12-bit byte counter from 0.
//  - TERM: TLP emits END_BYTE (tlpend) or EDB_BYTE (tlpedb if nullify); DLLP emits DLLP_PAD (dllpend).
//  - tx_seq increments (mod 4096, 4095->0) when the TLP terminator is emitted, nullified or not; DLLPs do not.
//  - Early in_eop (count<limit-1): remaining bytes padded 8'h00 typed data; terminator forced EDB; frame_err pulse.
//  - Last payload byte without in_eop: EDB emitted, frame_err pulse, then DROP.
//  - DROP: in_ready=1, bytes discarded, no output until in_eop accepted, then IDLE.
//  - TERM->IDLE; a waiting in_sop may start its token the cycle after the terminator is loaded (no idle gap required).
//  - in_ready is 0 in IDLE (except discard), token and TERM states.
// TESTING
//  - TLP len_dw=1, bytes 11 22 33 44, tx_seq=0 -> 1F 00 00 00 11 22 33 44 1F; STP3 tlpstart, 4x data, tlpend; tx_seq=1.
//  - DLLP bytes 00..05 -> F0 AC 00 01 02 03 04 05 00; types 0,dllpstart,6x data,dllpend; tx_seq unchanged.
//  - TLP len_dw=0x12A nullified -> STP0=AF STP1=12, 1192 data bytes, C0 tlpedb, tx_seq increments.
//  - out_ready low 3 cycles mid-payload -> out_data stable, in_ready 0, no byte lost or duplicated.
//  - TLP len_dw=2 with in_eop on 3rd byte -> 5x 00 pad, C0, one frame_err pulse; tx_seq=4095 wraps to 0 after it.
//  - rst asserted mid-TLP -> next cycle out_valid=0, tx_seq=0; following TLP framed normally with seq 0.

Source files
------------

// File: rtl/gen3_frame_tx.sv
// Gen3 128b/130b transmit framer: wraps TLP/DLLP byte streams in STP/SDP tokens and
// END/EDB/pad terminators, tagging each output byte with the receiver's type code.
module gen3_frame_tx #(
    parameter logic [7:0] END_BYTE = 8'h1F,
    parameter logic [7:0] EDB_BYTE = 8'hC0,
    parameter logic [7:0] DLLP_PAD = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_is_dllp,
    input  logic [9:0]  in_len_dw,
    input  logic        in_nullify,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [1:0]  out_sync_header,
    output logic [5:0]  out_type,
    output logic [11:0] tx_seq,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_STP0, S_STP1, S_STP2, S_STP3, S_SDP0, S_SDP1, S_PAYLOAD, S_TERM, S_DROP
    } state_t;

    localparam logic [5:0] T_OTHER     = 6'b000000;
    localparam logic [5:0] T_DATA      = 6'b100000;
    localparam logic [5:0] T_TLPSTART  = 6'b010000;
    localparam logic [5:0] T_TLPEND    = 6'b001000;
    localparam logic [5:0] T_DLLPEND   = 6'b000100;
    localparam logic [5:0] T_DLLPSTART = 6'b000010;
    localparam logic [5:0] T_TLPEDB    = 6'b000001;

    state_t      state, state_n;
    logic        is_dllp, is_dllp_n;
    logic [9:0]  len_dw, len_dw_n;
    logic        nullify, nullify_n;
    logic [11:0] cnt, cnt_n;
    logic        pad, pad_n;
    logic        force_edb, force_edb_n;
    logic        drop_after, drop_after_n;
    logic        out_valid_n;
    logic [7:0]  out_data_n;
    logic [5:0]  out_type_n;
    logic [11:0] tx_seq_n;
    logic        frame_err_n;
    logic        in_ready_c;

    logic        adv;
    logic [11:0] limit;
    logic        last;

    assign adv             = !out_valid || out_ready;
    assign limit           = is_dllp ? 12'd6 : {len_dw, 2'b00};
    assign last            = (cnt == limit - 12'd1);
    assign out_sync_header = out_valid ? 2'b01 : 2'b00;
    assign in_ready        = in_ready_c && !rst;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_n      = state;
        is_dllp_n    = is_dllp;
        len_dw_n     = len_dw;
        nullify_n    = nullify;
        cnt_n        = cnt;
        pad_n        = pad;
        force_edb_n  = force_edb;
        drop_after_n = drop_after;
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        out_type_n   = out_type;
        tx_seq_n     = tx_seq;
        frame_err_n  = 1'b0;
        in_ready_c   = 1'b0;

        // An advancing output register empties unless the state below loads a byte.
        if (adv) begin
            out_valid_n = 1'b0;
            out_data_n  = 8'h00;
            out_type_n  = T_OTHER;
        end

        case (state)
            S_IDLE: begin
                if (in_valid && in_sop) begin
                    is_dllp_n    = in_is_dllp;
                    len_dw_n     = in_len_dw;
                    nullify_n    = in_nullify;
                    cnt_n        = 12'd0;
                    pad_n        = 1'b0;
                    force_edb_n  = 1'b0;
                    drop_after_n = 1'b0;
                    if (!in_is_dllp && in_len_dw == 10'd0) begin
                        state_n     = S_DROP;
                        frame_err_n = 1'b1;
                    end else begin
                        state_n = in_is_dllp ? S_SDP0 : S_STP0;
                    end
                end else if (in_valid) begin
                    in_ready_c  = 1'b1;
                    frame_err_n = 1'b1;
                end
            end
            S_STP0: if (adv) begin
                out_valid_n = 1'b1; out_data_n = {len_dw[3:0], 4'hF}; state_n = S_STP1;
            end
            S_STP1: if (adv) begin
                out_valid_n = 1'b1; out_data_n = {2'b00, len_dw[9:4]}; state_n = S_STP2;
            end
            S_STP2: if (adv) begin
                out_valid_n = 1'b1; out_data_n = {4'h0, tx_seq[11:8]}; state_n = S_STP3;
            end
            S_STP3: if (adv) begin
                out_valid_n = 1'b1; out_data_n = tx_seq[7:0]; out_type_n = T_TLPSTART;
                state_n = S_PAYLOAD;
            end
            S_SDP0: if (adv) begin
                out_valid_n = 1'b1; out_data_n = 8'hF0; state_n = S_SDP1;
            end
            S_SDP1: if (adv) begin
                out_valid_n = 1'b1; out_data_n = 8'hAC; out_type_n = T_DLLPSTART;
                state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                in_ready_c = adv && !pad;
                if (adv && (pad || in_valid)) begin
                    out_valid_n = 1'b1;
                    out_data_n  = pad ? 8'h00 : in_data;
                    out_type_n  = T_DATA;
                    cnt_n       = cnt + 12'd1;
                    if (!pad && in_eop)
                        nullify_n = in_nullify;
                    if (last) begin
                        state_n = S_TERM;
                        // Packet ran out of room before its eop: kill it and flush the rest.
                        if (!pad && !in_eop) begin
                            force_edb_n  = 1'b1;
                            drop_after_n = 1'b1;
                            frame_err_n  = 1'b1;
                        end
                    end else if (!pad && in_eop) begin
                        pad_n       = 1'b1;
                        force_edb_n = 1'b1;
                        frame_err_n = 1'b1;
                    end
                end
            end
            S_TERM: if (adv) begin
                out_valid_n = 1'b1;
                if (force_edb || (!is_dllp && nullify)) begin
                    out_data_n = EDB_BYTE; out_type_n = T_TLPEDB;
                end else if (!is_dllp) begin
                    out_data_n = END_BYTE; out_type_n = T_TLPEND;
                end else begin
                    out_data_n = DLLP_PAD; out_type_n = T_DLLPEND;
                end
                if (!is_dllp)
                    tx_seq_n = tx_seq + 12'd1;
                state_n = drop_after ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                in_ready_c = 1'b1;
                if (in_valid && in_eop)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            is_dllp    <= 1'b0;
            len_dw     <= 10'd0;
            nullify    <= 1'b0;
            cnt        <= 12'd0;
            pad        <= 1'b0;
            force_edb  <= 1'b0;
            drop_after <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_type   <= T_OTHER;
            tx_seq     <= 12'd0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            is_dllp    <= is_dllp_n;
            len_dw     <= len_dw_n;
            nullify    <= nullify_n;
            cnt        <= cnt_n;
            pad        <= pad_n;
            force_edb  <= force_edb_n;
            drop_after <= drop_after_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_type   <= out_type_n;
            tx_seq     <= tx_seq_n;
            frame_err  <= frame_err_n;
        end
    end

endmodule

// File: tb/tb_gen3_frame_tx.sv
// Self-checking bench for gen3_frame_tx: table of packet vectors with hand-computed framing,
// plus reset-abort, stall and sequence-wrap sequences.
module tb_gen3_frame_tx;

    localparam logic [5:0] T_OTHER     = 6'b000000;
    localparam logic [5:0] T_DATA      = 6'b100000;
    localparam logic [5:0] T_TLPSTART  = 6'b010000;
    localparam logic [5:0] T_TLPEND    = 6'b001000;
    localparam logic [5:0] T_DLLPEND   = 6'b000100;
    localparam logic [5:0] T_DLLPSTART = 6'b000010;
    localparam logic [5:0] T_TLPEDB    = 6'b000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        in_is_dllp = 1'b0;
    logic [9:0]  in_len_dw = 10'd0;
    logic        in_nullify = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [1:0]  out_sync_header;
    logic [5:0]  out_type;
    logic [11:0] tx_seq;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    logic [11:0] seq_model = 12'd0;

    typedef struct {
        bit          is_dllp;
        logic [9:0]  len_dw;
        bit          nullify;
        int          n_in;      // bytes offered; in_eop on the last one
        logic [7:0]  seed;      // byte i = seed + step*i
        logic [7:0]  step;
        int          n_tok;     // 4 STP, 2 SDP, 0 none (and no terminator)
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n_data;    // data-typed bytes out, last n_pad of them 00
        int          n_pad;
        logic [7:0]  term;
        logic [5:0]  term_t;
        int          exp_ferr;
        logic [11:0] exp_seq;
        int          stall_at;  // output index to hold out_ready low 3 cycles, -1 none
    } vec_t;

    vec_t tbl[9];

    gen3_frame_tx dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_is_dllp(in_is_dllp),
        .in_len_dw(in_len_dw), .in_nullify(in_nullify),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sync_header(out_sync_header), .out_type(out_type),
        .tx_seq(tx_seq), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v, input int idx);
        if (idx < v.n_in) begin
            in_valid   = 1'b1;
            in_data    = 8'(v.seed + v.step * idx);
            in_sop     = (idx == 0);
            in_eop     = (idx == v.n_in - 1);
            in_is_dllp = v.is_dllp;
            in_len_dw  = v.len_dw;
            in_nullify = v.nullify;
        end else begin
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [7:0] ed[$];
        logic [5:0] et[$];
        int idx = 0, rcv = 0, ferr = 0, stalled = 0, cyc = 0;
        bit in_fire, out_fire;
        if (v.n_tok == 4) begin
            ed.push_back(v.b0); et.push_back(T_OTHER);
            ed.push_back(v.b1); et.push_back(T_OTHER);
            ed.push_back({4'h0, seq_model[11:8]}); et.push_back(T_OTHER);
            ed.push_back(seq_model[7:0]); et.push_back(T_TLPSTART);
        end else if (v.n_tok == 2) begin
            ed.push_back(v.b0); et.push_back(T_OTHER);
            ed.push_back(v.b1); et.push_back(T_DLLPSTART);
        end
        for (int i = 0; i < v.n_data; i++) begin
            ed.push_back((i < v.n_data - v.n_pad) ? 8'(v.seed + v.step * i) : 8'h00);
            et.push_back(T_DATA);
        end
        if (v.n_tok != 0) begin
            ed.push_back(v.term); et.push_back(v.term_t);
        end

        set_in(v, 0);
        out_ready = 1'b1;
        while ((idx < v.n_in || rcv < ed.size()) && cyc < 20000) begin
            @(negedge clk);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (frame_err) ferr++;
            if (!out_ready && rcv < ed.size()) begin
                check({name, "_stall_data"}, {out_valid, out_data}, {1'b1, ed[rcv]});
                check({name, "_stall_in_ready"}, in_ready, 0);
            end
            if (out_fire) begin
                if (rcv < ed.size())
                    check($sformatf("%s_byte%0d", name, rcv),
                          {out_type, out_data, out_sync_header}, {et[rcv], ed[rcv], 2'b01});
                else
                    check({name, "_extra_byte"}, out_data, 32'hFFFF_FFFF);
                rcv++;
            end
            @(posedge clk);
            #1;
            if (in_fire) idx++;
            set_in(v, idx);
            if (rcv == v.stall_at && stalled < 3) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            cyc++;
        end
        check({name, "_bytes_in"}, idx, v.n_in);
        check({name, "_bytes_out"}, rcv, ed.size());
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (frame_err) ferr++;
            if (out_valid) check({name, "_trailing_byte"}, out_data, 32'hFFFF_FFFF);
        end
        check({name, "_frame_err"}, ferr, v.exp_ferr);
        check({name, "_tx_seq"}, tx_seq, v.exp_seq);
        seq_model = v.exp_seq;
    endtask

    initial begin
        bit fire;
        vec_t w;

        tbl[0] = '{is_dllp:0, len_dw:10'd1, nullify:0, n_in:4, seed:8'h11, step:8'h11,
                   n_tok:4, b0:8'h1F, b1:8'h00, n_data:4, n_pad:0, term:8'h1F, term_t:T_TLPEND,
                   exp_ferr:0, exp_seq:12'd1, stall_at:-1};
        tbl[1] = '{is_dllp:1, len_dw:10'd0, nullify:0, n_in:6, seed:8'h00, step:8'h01,
                   n_tok:2, b0:8'hF0, b1:8'hAC, n_data:6, n_pad:0, term:8'h00, term_t:T_DLLPEND,
                   exp_ferr:0, exp_seq:12'd1, stall_at:-1};
        tbl[2] = '{is_dllp:0, len_dw:10'h12A, nullify:1, n_in:1192, seed:8'h00, step:8'h01,
                   n_tok:4, b0:8'hAF, b1:8'h12, n_data:1192, n_pad:0, term:8'hC0, term_t:T_TLPEDB,
                   exp_ferr:0, exp_seq:12'd2, stall_at:-1};
        tbl[3] = '{is_dllp:0, len_dw:10'd2, nullify:0, n_in:3, seed:8'hA0, step:8'h01,
                   n_tok:4, b0:8'h2F, b1:8'h00, n_data:8, n_pad:5, term:8'hC0, term_t:T_TLPEDB,
                   exp_ferr:1, exp_seq:12'd3, stall_at:-1};
        tbl[4] = '{is_dllp:0, len_dw:10'd1, nullify:0, n_in:6, seed:8'h50, step:8'h01,
                   n_tok:4, b0:8'h1F, b1:8'h00, n_data:4, n_pad:0, term:8'hC0, term_t:T_TLPEDB,
                   exp_ferr:1, exp_seq:12'd4, stall_at:-1};
        tbl[5] = '{is_dllp:0, len_dw:10'd2, nullify:1, n_in:8, seed:8'h30, step:8'h03,
                   n_tok:4, b0:8'h2F, b1:8'h00, n_data:8, n_pad:0, term:8'hC0, term_t:T_TLPEDB,
                   exp_ferr:0, exp_seq:12'd5, stall_at:6};
        tbl[6] = '{is_dllp:0, len_dw:10'd0, nullify:0, n_in:2, seed:8'h77, step:8'h01,
                   n_tok:0, b0:8'h00, b1:8'h00, n_data:0, n_pad:0, term:8'h00, term_t:T_OTHER,
                   exp_ferr:1, exp_seq:12'd5, stall_at:-1};
        tbl[7] = '{is_dllp:1, len_dw:10'd0, nullify:0, n_in:3, seed:8'h90, step:8'h01,
                   n_tok:2, b0:8'hF0, b1:8'hAC, n_data:6, n_pad:3, term:8'hC0, term_t:T_TLPEDB,
                   exp_ferr:1, exp_seq:12'd5, stall_at:-1};
        tbl[8] = '{is_dllp:1, len_dw:10'd0, nullify:0, n_in:6, seed:8'hC8, step:8'h01,
                   n_tok:2, b0:8'hF0, b1:8'hAC, n_data:6, n_pad:0, term:8'h00, term_t:T_DLLPEND,
                   exp_ferr:0, exp_seq:12'd5, stall_at:4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_type", out_type, 0);
        check("rst_sync_header", out_sync_header, 0);
        check("rst_tx_seq", tx_seq, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset in the middle of a TLP payload aborts it with no terminator
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_is_dllp = 1'b0;
        in_len_dw = 10'd4; in_nullify = 1'b0; in_data = 8'h40; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                in_sop  = 1'b0;
                in_data = in_data + 8'h01;
            end
        end
        check("pre_rst_tx_seq", tx_seq, 5);
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_tx_seq", tx_seq, 0);
        check("midrst_frame_err", frame_err, 0);
        rst = 1'b0;
        seq_model = 12'd0;
        @(negedge clk);
        check("midrst_no_output", out_valid, 0);
        @(posedge clk);
        #1;
        run_vec(tbl[0], "post_rst");

        // Advance the sequence number to 4095, then wrap on an errored TLP
        for (int k = 0; k < 4094; k++) begin
            w = tbl[0];
            w.seed = 8'(k);
            w.step = 8'h01;
            w.exp_seq = seq_model + 12'd1;
            run_vec(w, $sformatf("bulk%0d", k));
        end
        check("seq_at_max", tx_seq, 12'hFFF);
        w = tbl[3];
        w.exp_seq = 12'd0;
        run_vec(w, "wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
